// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of a UART transmitter: valid/ready write port in, send/busy handshake out.
// The head byte is only popped once the UART acknowledges it by raising busy.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2   = 4,
  parameter int BUSY_TIMEOUT = 1023
) (
  input  logic                  ipClk,
  input  logic                  ipReset,
  input  logic [7:0]            ipWrData,
  input  logic                  ipWrValid,
  output logic                  opWrReady,
  output logic [7:0]            opTxData,
  output logic                  opTxSend,
  input  logic                  ipTxBusy,
  output logic [DEPTH_LOG2:0]   opCount,
  output logic                  opEmpty,
  output logic                  opOverflow,
  output logic                  opTimeout,
  output logic [1:0]            opState
);

  // Handshakes: a byte moves on the write port in any cycle where
  // ipWrValid && opWrReady; the UART takes opTxData when it sees opTxSend
  // and answers by raising ipTxBusy, which is what pops the head entry.

  localparam int Depth  = 1 << DEPTH_LOG2;
  localparam int TimerW = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [DEPTH_LOG2:0]   CountOne  = 1;
  localparam logic [DEPTH_LOG2:0]   CountFull = Depth[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2-1:0] PtrOne    = 1;
  localparam logic [TimerW-1:0]     TimerOne  = 1;
  localparam logic [TimerW-1:0]     TimerLast = TimerW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    stIdle    = 2'd0,
    stSend    = 2'd1,
    stRelease = 2'd2
  } state_t;

  state_t                  state;
  logic [7:0]              mem [Depth];
  logic [DEPTH_LOG2-1:0]   wrPtr;
  logic [DEPTH_LOG2-1:0]   rdPtr;
  logic [TimerW-1:0]       timer;
  logic                    wrEn;
  logic                    pop;

  assign opWrReady = (opCount != CountFull);
  assign opEmpty   = (opCount == '0);
  assign opState   = state;
  assign wrEn      = ipWrValid && opWrReady;
  assign pop       = (state == stSend) && ipTxBusy;

  always_ff @(posedge ipClk) begin
    if (wrEn) mem[wrPtr] <= ipWrData;
  end

  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      opCount    <= '0;
      opOverflow <= 1'b0;
    end else begin
      opOverflow <= ipWrValid && !opWrReady;
      if (wrEn) wrPtr <= wrPtr + PtrOne;
      if (pop)  rdPtr <= rdPtr + PtrOne;
      case ({wrEn, pop})
        2'b10:   opCount <= opCount + CountOne;
        2'b01:   opCount <= opCount - CountOne;
        default: opCount <= opCount;
      endcase
    end
  end

  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      state     <= stIdle;
      opTxSend  <= 1'b0;
      opTxData  <= 8'h00;
      opTimeout <= 1'b0;
      timer     <= '0;
    end else begin
      opTimeout <= 1'b0;
      case (state)
        stIdle: begin
          opTxSend <= 1'b0;
          if (!opEmpty && !ipTxBusy) begin
            opTxData <= mem[rdPtr];
            timer    <= '0;
            opTxSend <= 1'b1;
            state    <= stSend;
          end
        end
        stSend: begin
          if (ipTxBusy) begin
            opTxSend <= 1'b0;
            state    <= stRelease;
          end else if (timer == TimerLast) begin
            // Give up on this attempt; the head stays queued and is re-sent from IDLE.
            opTimeout <= 1'b1;
            opTxSend  <= 1'b0;
            state     <= stIdle;
          end else if (timer != '1) begin
            timer <= timer + TimerOne;
          end
        end
        stRelease: begin
          opTxSend <= 1'b0;
          state    <= stIdle;
        end
        default: begin
          opTxSend <= 1'b0;
          state    <= stIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: behavioural UART busy model, per-cycle reference model of
// count/ready/overflow and a byte scoreboard checked at every UART acceptance.
module tb_uart_tx_fifo;

  localparam int DepthLog2   = 4;
  localparam int Depth       = 1 << DepthLog2;
  localparam int BusyTimeout = 1023;

  logic               clk;
  logic               reset;
  logic [7:0]         wrData;
  logic               wrValid;
  logic               wrReady;
  logic [7:0]         txData;
  logic               txSend;
  logic               txBusy;
  logic [DepthLog2:0] count;
  logic               empty;
  logic               overflow;
  logic               timeout;
  logic [1:0]         state;

  uart_tx_fifo #(.DEPTH_LOG2(DepthLog2), .BUSY_TIMEOUT(BusyTimeout)) dut (
    .ipClk(clk), .ipReset(reset), .ipWrData(wrData), .ipWrValid(wrValid),
    .opWrReady(wrReady), .opTxData(txData), .opTxSend(txSend), .ipTxBusy(txBusy),
    .opCount(count), .opEmpty(empty), .opOverflow(overflow), .opTimeout(timeout),
    .opState(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // UART busy model
  logic modelBusy;
  logic busyHold;
  logic uartOn;
  int   busyDelay;
  int   busyLen;
  assign txBusy = modelBusy | busyHold;

  initial begin
    modelBusy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (uartOn && txSend && !modelBusy) begin
        repeat (busyDelay) begin @(posedge clk); #1; end
        modelBusy = 1'b1;
        repeat (busyLen) begin @(posedge clk); #1; end
        modelBusy = 1'b0;
      end
    end
  end

  // scoreboard and reference model
  logic [7:0] expQ[$];
  int         expCount;
  logic       expOvf;
  logic       monOn;
  logic       prevSend;
  logic [7:0] prevData;
  int         popCount;

  always @(negedge clk) begin
    if (monOn) begin
      if (reset) begin
        expCount = 0;
        expOvf   = 1'b0;
        expQ.delete();
        prevSend = 1'b0;
      end else begin
        logic acc;
        logic popNow;
        check("count", count, expCount);
        check("wr_ready", wrReady, expCount != Depth);
        check("empty", empty, expCount == 0);
        check("overflow", overflow, expOvf);
        if (prevSend && txSend) check("data_stable", txData, prevData);
        acc    = wrValid && (expCount != Depth);
        popNow = txSend && txBusy;
        expOvf = wrValid && (expCount == Depth);
        if (acc) expQ.push_back(wrData);
        if (popNow) begin
          popCount++;
          check("q_nonempty", expQ.size() != 0, 1);
          if (expQ.size() != 0) check("tx_data", txData, expQ.pop_front());
        end
        expCount = expCount + int'(acc) - int'(popNow);
        prevSend = txSend;
        prevData = txData;
      end
    end
  end

  // driver tasks (called at posedge + #1)
  task automatic wr(input logic [7:0] d);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    wrData  = d;
    wrValid = 1'b1;
    while (!acc && n < 500) begin
      @(negedge clk);
      acc = wrReady;
      @(posedge clk); #1;
      n++;
    end
    wrValid = 1'b0;
    check("wr_accepted", acc, 1);
  endtask

  task automatic wait_send(input int bound);
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if (txSend) break;
    end
    check("send_seen", txSend, 1);
  endtask

  task automatic wait_empty(input int bound);
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if (empty && !txSend && !txBusy) break;
    end
    check("drained", {empty, txSend, txBusy}, 3'b100);
    check("q_drained", expQ.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int sendCycles;
    int popsBefore;
    reset = 1'b1; wrData = 8'h00; wrValid = 1'b0;
    busyHold = 1'b0; uartOn = 1'b1; busyDelay = 10; busyLen = 3;
    expCount = 0; expOvf = 1'b0; prevSend = 1'b0; prevData = 8'h00; popCount = 0;
    monOn = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    monOn = 1'b1;

    // reset state
    @(negedge clk);
    check("rst_send", txSend, 0);
    check("rst_data", txData, 8'h00);
    check("rst_timeout", timeout, 0);
    check("rst_state", state, 0);
    check("rst_count", count, 0);
    @(posedge clk); #1;

    // single byte, busy 10 cycles after send
    wr(8'hA5);
    @(negedge clk);
    check("lat_send_low", txSend, 0);
    @(negedge clk);
    check("lat_send_high", txSend, 1);
    check("lat_data", txData, 8'hA5);
    for (int n = 0; n < 50; n++) begin
      if (txBusy) break;
      @(negedge clk);
    end
    check("ack_send", txSend, 1);
    check("ack_count", count, 1);
    @(negedge clk);
    check("rel_send", txSend, 0);
    check("rel_count", count, 0);
    wait_empty(100);

    // burst to full with busy held, then overflow
    busyHold = 1'b1; busyDelay = 2; busyLen = 3;
    for (int i = 0; i < Depth; i++) wr(8'(i));
    @(negedge clk);
    check("full_count", count, Depth);
    check("full_ready", wrReady, 0);
    @(posedge clk); #1;
    wrData = 8'h10; wrValid = 1'b1;
    @(posedge clk); #1;
    wrValid = 1'b0;
    @(negedge clk);
    check("ovf_pulse", overflow, 1);
    check("ovf_count", count, Depth);
    @(negedge clk);
    check("ovf_single", overflow, 0);
    @(posedge clk); #1;
    busyHold = 1'b0;
    wait_empty(2000);

    // full FIFO kept topped up while draining, 40 bytes, pointers wrap
    busyHold = 1'b1;
    for (int i = 0; i < Depth; i++) wr(8'h20 + 8'(i));
    busyHold = 1'b0;
    for (int i = 0; i < 24; i++) wr(8'h30 + 8'($urandom_range(0, 15)) + 8'(i * 16));
    wait_empty(3000);

    // UART never answers: timeout and retry of the same byte
    uartOn = 1'b0;
    wr(8'h3C);
    wait_send(20);
    sendCycles = 1;
    for (int n = 0; n < 1200; n++) begin
      @(negedge clk);
      if (timeout) break;
      if (txSend) sendCycles++;
    end
    check("timeout_pulse", timeout, 1);
    check("timeout_cycles", sendCycles, BusyTimeout);
    check("timeout_count", count, 1);
    wait_send(5);
    check("timeout_single", timeout, 0);
    check("retry_data", txData, 8'h3C);
    check("retry_count", count, 1);
    @(posedge clk); #1;
    uartOn = 1'b1; busyDelay = $urandom_range(1, 4); busyLen = 4;
    wait_empty(200);

    // reset while sending with 5 bytes queued
    uartOn = 1'b0;
    for (int i = 0; i < 5; i++) wr(8'h50 + 8'(i));
    wait_send(20);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_send", txSend, 0);
    check("rst_mid_count", count, 0);
    check("rst_mid_empty", empty, 1);
    @(posedge clk); #1;
    uartOn = 1'b1; busyDelay = 3; busyLen = 5;
    wr(8'h60);
    wr(8'h61);
    wait_empty(200);

    // "Hi\n" with baud-length busy (10 bits x 434 cycles)
    busyDelay = 1; busyLen = 4340;
    popsBefore = popCount;
    wr(8'h48);
    wr(8'h69);
    wr(8'h0A);
    wait_empty(20000);
    check("hi_pops", popCount - popsBefore, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
